// File: rtl/max_sub_block_16.sv
// Softmax input normalisation: buffers one vector, tracks its signed maximum while
// loading, then streams x_i - max. Optional macro MAX_SUB_SAT_EN clamps underflow to 0x8001.
module max_sub_block_16 #(
    parameter int data_size   = 16,
    parameter int num_samples = 10,
    parameter int addr_size   = 8
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [data_size-1:0] data_i,
    input  logic                 data_valid_i,
    output logic                 ready_o,
    output logic [data_size-1:0] sub_data_o,
    output logic                 sub_data_valid_o,
    output logic                 sub_done_o
);

    localparam int IDX_W = (num_samples > 1) ? $clog2(num_samples) : 1;
    localparam logic [addr_size-1:0] LAST_IDX = addr_size'(num_samples - 1);
    localparam logic [addr_size-1:0] CNT_END  = addr_size'(num_samples);

    typedef enum logic [1:0] {S_LOAD, S_SUB, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [addr_size-1:0]  r_load_cnt;
    logic [addr_size-1:0]  r_sub_cnt;
    logic [data_size-1:0]  r_max;
    logic [data_size-1:0]  r_buf [0:num_samples-1];
    logic [data_size-1:0]  r_rd;
    logic                  r_rd_vld;
    logic [data_size-1:0]  r_sub_data;
    logic                  r_sub_valid;
    logic                  r_sub_done;
    logic                  r_clr_done;
    logic                  w_accept;
    logic                  w_load_last;
    logic                  w_drained;
    logic [data_size-1:0]  w_sub_res;

    assign ready_o          = (r_state == S_LOAD);
    assign w_accept         = ready_o && data_valid_i;
    assign w_load_last      = w_accept && (r_load_cnt == LAST_IDX);
    // Read stage has issued every index; the output stage is writing the last one now.
    assign w_drained        = (r_state == S_SUB) && (r_sub_cnt == CNT_END);
    assign sub_data_o       = r_sub_data;
    assign sub_data_valid_o = r_sub_valid;
    assign sub_done_o       = r_sub_done;

`ifdef MAX_SUB_SAT_EN
    localparam logic [data_size:0] SAT_MIN = {2'b11, {(data_size-2){1'b0}}, 1'b1};
    logic signed [data_size:0] w_diff;
    assign w_diff    = $signed({r_rd[data_size-1], r_rd}) - $signed({r_max[data_size-1], r_max});
    assign w_sub_res = (w_diff < $signed(SAT_MIN)) ? SAT_MIN[data_size-1:0] : w_diff[data_size-1:0];
`else
    assign w_sub_res = r_rd - r_max;
`endif

    always_ff @(posedge clock_i) begin
        if (reset_i) r_state <= S_LOAD;
        else         r_state <= w_next;
    end

    // NOTE: default first so every path assigns w_next and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:  if (w_load_last) w_next = S_SUB;
            S_SUB:   if (w_drained) w_next = S_DONE;
            S_DONE:  w_next = S_LOAD;
            default: w_next = S_LOAD;
        endcase
    end

    // NOTE: the sample buffer has no reset; it is always written before it is read.
    always_ff @(posedge clock_i) begin
        if (w_accept) r_buf[r_load_cnt[IDX_W-1:0]] <= data_i;
    end

    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_load_cnt  <= '0;
            r_sub_cnt   <= '0;
            r_max       <= '0;
            r_rd        <= '0;
            r_rd_vld    <= 1'b0;
            r_sub_data  <= '0;
            r_sub_valid <= 1'b0;
            r_sub_done  <= 1'b0;
            r_clr_done  <= 1'b0;
        end else begin
            r_clr_done <= 1'b0;
            if (w_accept) begin
                r_load_cnt <= w_load_last ? '0 : r_load_cnt + addr_size'(1);
                if (r_load_cnt == '0 || $signed(data_i) > $signed(r_max)) r_max <= data_i;
                if (r_load_cnt == '0) r_clr_done <= 1'b1;
            end

            r_rd_vld <= 1'b0;
            if (r_state == S_SUB && r_sub_cnt != CNT_END) begin
                r_rd      <= r_buf[r_sub_cnt[IDX_W-1:0]];
                r_rd_vld  <= 1'b1;
                r_sub_cnt <= r_sub_cnt + addr_size'(1);
            end

            r_sub_valid <= r_rd_vld;
            if (r_rd_vld) r_sub_data <= w_sub_res;

            // Done is a sticky level until the next vector's first sample has been taken.
            if (r_state == S_DONE) begin
                r_sub_cnt  <= '0;
                r_sub_done <= 1'b1;
            end else if (r_clr_done) begin
                r_sub_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_max_sub_block_16.sv
// Directed, table-driven bench for max_sub_block_16; expected values are hand-computed.
// Saturating expectations are selected with the same MAX_SUB_SAT_EN macro as the RTL.
module tb_max_sub_block_16;

    localparam int N = 10;

    typedef logic [N-1:0][15:0] row_t;
    typedef struct {
        string name;
        row_t  din;
        row_t  dexp;
        int    gap;
        bit    hold;
    } vec_t;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [15:0] data_i = '0;
    logic        data_valid_i = 1'b0;
    logic        ready_o;
    logic [15:0] sub_data_o;
    logic        sub_data_valid_o;
    logic        sub_done_o;

    int checks = 0;
    int errors = 0;
    vec_t vecs [6];

    max_sub_block_16 dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .data_i           (data_i),
        .data_valid_i     (data_valid_i),
        .ready_o          (ready_o),
        .sub_data_o       (sub_data_o),
        .sub_data_valid_o (sub_data_valid_o),
        .sub_done_o       (sub_done_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock_i);
        #1;
    endtask

    function automatic row_t mk(input logic [15:0] a0, a1, a2, a3, a4, a5, a6, a7, a8, a9);
        row_t r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3; r[4] = a4;
        r[5] = a5; r[6] = a6; r[7] = a7; r[8] = a8; r[9] = a9;
        return r;
    endfunction

    task automatic send(input vec_t v, input bit done_before);
        for (int i = 0; i < N; i++) begin
            repeat (v.gap) begin
                data_valid_i = 1'b0;
                data_i       = 16'h7FFF;
                tick();
            end
            if (i == 0) begin
                check({v.name, " done before first accept"}, sub_done_o, done_before);
                check({v.name, " ready in load"}, ready_o, 1);
            end
            data_i       = v.din[i];
            data_valid_i = 1'b1;
            tick();
            if (i == 0) check({v.name, " done held on accept edge"}, sub_done_o, done_before);
            if (i == 1) check({v.name, " done cleared"}, sub_done_o, 0);
        end
        data_valid_i = v.hold;
        data_i       = 16'h7FFF;
    endtask

    task automatic collect(input vec_t v);
        int nout   = 0;
        int first  = -1;
        int done_c = -1;
        for (int c = 1; c <= 40 && done_c < 0; c++) begin
            tick();
            if (sub_data_valid_o) begin
                if (first < 0) first = c;
                if (nout < N) check($sformatf("%s out[%0d]", v.name, nout), sub_data_o, v.dexp[nout]);
                nout++;
            end
            if (c == N + 1) check({v.name, " ready low during last output"}, ready_o, 0);
            if (sub_done_o) begin
                done_c = c;
                check({v.name, " valid low at done"}, sub_data_valid_o, 0);
                check({v.name, " ready back at done"}, ready_o, 1);
            end
            data_valid_i = v.hold && !ready_o;
        end
        data_valid_i = 1'b0;
        check({v.name, " output count"}, nout, N);
        check({v.name, " first output latency"}, first, 2);
        check({v.name, " done cycle"}, done_c, N + 2);
    endtask

    initial begin
        vecs[0] = '{"ramp", mk(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500,
                               16'h0600, 16'h0700, 16'h0800, 16'h0900, 16'h0A00),
                            mk(16'hF700, 16'hF800, 16'hF900, 16'hFA00, 16'hFB00,
                               16'hFC00, 16'hFD00, 16'hFE00, 16'hFF00, 16'h0000), 0, 1'b0};
        vecs[1] = '{"equal_hold", mk(16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00,
                                     16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00),
                                  mk(16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                                     16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 0, 1'b1};
`ifdef MAX_SUB_SAT_EN
        vecs[2] = '{"extremes", mk(16'h7F00, 16'h8100, 16'h0000, 16'hFF01, 16'h8100,
                                   16'h0100, 16'hFF00, 16'h1000, 16'h7E00, 16'h7F00),
                                mk(16'h0000, 16'h8001, 16'h8100, 16'h8001, 16'h8001,
                                   16'h8200, 16'h8001, 16'h9100, 16'hFF00, 16'h0000), 0, 1'b0};
`else
        vecs[2] = '{"extremes", mk(16'h7F00, 16'h8100, 16'h0000, 16'hFF01, 16'h8100,
                                   16'h0100, 16'hFF00, 16'h1000, 16'h7E00, 16'h7F00),
                                mk(16'h0000, 16'h0200, 16'h8100, 16'h8001, 16'h0200,
                                   16'h8200, 16'h8000, 16'h9100, 16'hFF00, 16'h0000), 0, 1'b0};
`endif
        vecs[3] = '{"negative", mk(16'hFE00, 16'hF000, 16'h8000, 16'hFD00, 16'hFF80,
                                   16'hFE00, 16'hC000, 16'hFF80, 16'h8000, 16'h9000),
                                mk(16'hFE80, 16'hF080, 16'h8080, 16'hFD80, 16'h0000,
                                   16'hFE80, 16'hC080, 16'h0000, 16'h8080, 16'h9080), 0, 1'b0};
        vecs[4] = vecs[0];
        vecs[4].name = "ramp_gapped";
        vecs[4].gap  = 2;
        vecs[5] = vecs[3];
        vecs[5].name = "negative_after_reset";

        reset_i = 1'b1;
        tick();
        tick();
        check("reset ready", ready_o, 1);
        check("reset valid", sub_data_valid_o, 0);
        check("reset data", sub_data_o, 0);
        check("reset done", sub_done_o, 0);
        reset_i = 1'b0;

        for (int k = 0; k < 5; k++) begin
            send(vecs[k], k != 0);
            collect(vecs[k]);
        end

        // Abort a vector mid-stream, then confirm a clean restart with no stale max.
        begin
            int seen = 0;
            send(vecs[0], 1'b1);
            for (int c = 0; c < 20 && seen < 4; c++) begin
                tick();
                if (sub_data_valid_o) seen++;
            end
            check("mid-sub outputs before reset", seen, 4);
            reset_i = 1'b1;
            tick();
            reset_i = 1'b0;
            check("mid reset ready", ready_o, 1);
            check("mid reset valid", sub_data_valid_o, 0);
            check("mid reset data", sub_data_o, 0);
            check("mid reset done", sub_done_o, 0);
            send(vecs[5], 1'b0);
            collect(vecs[5]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
